// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and operand signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU)
            || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH)
            || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the
// multiply/divide unit; master issues ops, slave is the unit.
interface muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;
    logic             div_by_zero;

    modport master (
        output in_valid, funct3, a, b, tag_in, flush, out_ready,
        input  in_ready, out_valid, result, tag_out, div_by_zero
    );

    modport slave (
        input  in_valid, funct3, a, b, tag_in, flush, out_ready,
        output in_ready, out_valid, result, tag_out, div_by_zero
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Bit-serial shift-add multiplier / restoring divider sharing one
// adder, plus the sign-correction and hi/lo select used in FIX.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] fix_result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_TOP = CW'(XLEN - 1);

    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   op;
    logic [CW-1:0]     cnt;
    logic [2:0]        f3;
    logic              neg_main;
    logic              neg_rem;

    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   ma;
    logic [XLEN-1:0]   mb;
    logic              op_div;
    logic [XLEN:0]     add_a;
    logic [XLEN:0]     add_b;
    logic [XLEN+1:0]   sum;
    logic              no_borrow;
    logic [XLEN:0]     mul_s;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    // operand magnitudes and the shared add/subtract step
    always_comb begin
        sa        = is_signed_a(funct3) & a[XLEN-1];
        sb        = is_signed_b(funct3) & b[XLEN-1];
        ma        = sa ? -a : a;
        mb        = sb ? -b : b;
        op_div    = f3[2];
        add_a     = op_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
        add_b     = op_div ? ~{1'b0, op} : {1'b0, op};
        sum       = {1'b0, add_a} + {1'b0, add_b}
                  + (XLEN+2)'(op_div);
        no_borrow = sum[XLEN+1];
        mul_s     = lo[0] ? sum[XLEN:0] : {1'b0, hi};
    end

    // operand load on accept, one product/quotient bit per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            op       <= '0;
            cnt      <= '0;
            f3       <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (load) begin
            f3       <= funct3;
            hi       <= '0;
            cnt      <= CNT_TOP;
            neg_main <= sa ^ sb;
            if (funct3[2]) begin
                lo      <= ma;
                op      <= mb;
                neg_rem <= sa;
            end else begin
                lo      <= mb;
                op      <= ma;
                neg_rem <= 1'b0;
            end
        end else if (step) begin
            cnt <= cnt - CW'(1);
            if (op_div) begin
                hi <= no_borrow ? sum[XLEN-1:0] : add_a[XLEN-1:0];
                lo <= {lo[XLEN-2:0], no_borrow};
            end else begin
                hi <= mul_s[XLEN:1];
                lo <= {mul_s[0], lo[XLEN-1:1]};
            end
        end
    end

    assign done = (cnt == '0);

    // sign correction and hi/lo select for the finished op
    always_comb begin
        prod     = {hi, lo};
        prod_fix = neg_main ? -prod : prod;
        quot     = neg_main ? -lo : lo;
        rem      = neg_rem ? -hi : hi;
        if (f3[2]) begin
            fix_result = f3[1] ? rem : quot;
        end else if (f3[1:0] == 2'b00) begin
            fix_result = prod_fix[XLEN-1:0];
        end else begin
            fix_result = prod_fix[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide unit: handshake FSM, special-case
// fast path and held output registers around the serial datapath.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic      clk,
    input logic      rst,
    muldiv_if.slave  bus
);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES    = '1;

    state_t           state_q;
    state_t           next_state;
    logic             accept;
    logic             special;
    logic             load;
    logic             step;
    logic             done;
    logic [XLEN-1:0]  fix_result;
    logic [XLEN-1:0]  spec_result;
    logic             spec_dbz;
    logic [TAG_W-1:0] tag_r;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;
    logic             valid_q;
    logic             dbz_q;

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = valid_q;
    assign bus.result      = result_q;
    assign bus.tag_out     = tag_q;
    assign bus.div_by_zero = dbz_q;
    assign accept          = bus.in_valid && bus.in_ready;

    // divide by zero and signed overflow bypass the serial datapath
    always_comb begin
        special     = 1'b0;
        spec_dbz    = 1'b0;
        spec_result = '0;
        if (bus.funct3[2]) begin
            if (bus.b == '0) begin
                special     = 1'b1;
                spec_dbz    = 1'b1;
                spec_result = bus.funct3[1] ? bus.a : ONES;
            end else if (!bus.funct3[0] && bus.a == MIN_VAL
                         && bus.b == ONES) begin
                special     = 1'b1;
                spec_result = bus.funct3[1] ? '0 : MIN_VAL;
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // next state and datapath controls; flush overrides everything
    always_comb begin
        next_state = state_q;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (special) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_CALC;
                        load       = 1'b1;
                    end
                end
            end
            S_CALC: begin
                step = 1'b1;
                if (done) begin
                    next_state = S_FIX;
                end
            end
            S_FIX: begin
                next_state = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    next_state = S_IDLE;
                end
            end
        endcase
        if (bus.flush) begin
            next_state = S_IDLE;
            load       = 1'b0;
            step       = 1'b0;
        end
    end

    // tag captured on accept for the serial path
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_r <= '0;
        end else if (accept && !bus.flush) begin
            tag_r <= bus.tag_in;
        end
    end

    // output registers, loaded only when entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            valid_q <= (next_state == S_DONE);
            if (!bus.flush) begin
                if (accept && special) begin
                    result_q <= spec_result;
                    tag_q    <= bus.tag_in;
                    dbz_q    <= spec_dbz;
                end else if (state_q == S_FIX) begin
                    result_q <= fix_result;
                    tag_q    <= tag_r;
                    dbz_q    <= 1'b0;
                end
            end
        end
    end

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .funct3     (bus.funct3),
        .a          (bus.a),
        .b          (bus.b),
        .done       (done),
        .fix_result (fix_result)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and model-checked bench for muldiv_unit at XLEN=32 and 16,
// with a scoreboard queue of expected responses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32), .TAG_W(5)) bus32 ();
    muldiv_if #(.XLEN(16), .TAG_W(5)) bus16 ();

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    muldiv_unit #(.XLEN(16), .TAG_W(5)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model32(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb, q;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        q  = 0;
        case (f3)
            F3_MUL:    begin p = ua * ub; return p[31:0]; end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h8000_0000;
                q = sa / sb;
                return q[31:0];
            end
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h0;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run32(input string name, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag,
                         input logic [31:0] exp_res, input int exp_lat);
        exp_t e;
        int   lat;
        e.res = exp_res;
        e.tag = tag;
        e.dbz = f3[2] && (b == 0);
        e.lat = exp_lat;
        sb.push_back(e);
        check({name, ".in_ready"}, bus32.in_ready, 1);
        bus32.funct3   = f3;
        bus32.a        = a;
        bus32.b        = b;
        bus32.tag_in   = tag;
        bus32.in_valid = 1'b1;
        tick();
        lat = 1;
        bus32.in_valid = 1'b0;
        bus32.funct3   = 3'($urandom);
        bus32.a        = $urandom;
        bus32.b        = $urandom;
        bus32.tag_in   = 5'($urandom);
        while (!bus32.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        check({name, ".lat"}, lat, e.lat);
        check({name, ".result"}, bus32.result, e.res);
        check({name, ".tag"}, bus32.tag_out, e.tag);
        check({name, ".dbz"}, bus32.div_by_zero, e.dbz);
        tick();
        check({name, ".retire"}, bus32.out_valid, 0);
    endtask

    task automatic run16(input string name, input logic [2:0] f3,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] tag,
                         input logic [15:0] exp_res, input int exp_lat);
        exp_t e;
        int   lat;
        e.res = {16'b0, exp_res};
        e.tag = tag;
        e.dbz = f3[2] && (b == 0);
        e.lat = exp_lat;
        sb.push_back(e);
        bus16.funct3   = f3;
        bus16.a        = a;
        bus16.b        = b;
        bus16.tag_in   = tag;
        bus16.in_valid = 1'b1;
        tick();
        lat = 1;
        bus16.in_valid = 1'b0;
        while (!bus16.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        check({name, ".lat"}, lat, e.lat);
        check({name, ".result"}, bus16.result, e.res);
        check({name, ".tag"}, bus16.tag_out, e.tag);
        check({name, ".dbz"}, bus16.div_by_zero, e.dbz);
        tick();
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] ra, rb;
        int          lat;
        int          seen;
        exp_t        e;

        rst = 1'b1;
        bus32.in_valid = 0; bus32.funct3 = 0; bus32.a = 0; bus32.b = 0;
        bus32.tag_in = 0; bus32.flush = 0; bus32.out_ready = 1;
        bus16.in_valid = 0; bus16.funct3 = 0; bus16.a = 0; bus16.b = 0;
        bus16.tag_in = 0; bus16.flush = 0; bus16.out_ready = 1;
        tick();
        tick();
        check("rst.in_ready", bus32.in_ready, 1);
        check("rst.out_valid", bus32.out_valid, 0);
        check("rst.result", bus32.result, 0);
        check("rst.tag", bus32.tag_out, 0);
        check("rst.dbz", bus32.div_by_zero, 0);
        check("rst16.out_valid", bus16.out_valid, 0);
        rst = 1'b0;
        tick();

        run32("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34);
        run32("mulh", F3_MULH, 32'hFFFF_FFFE, 32'd3, 5'd2,
              32'hFFFF_FFFF, 34);
        run32("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd3,
              32'h0000_0001, 34);
        run32("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 34);
        run32("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 34);
        run32("divu", F3_DIVU, 32'd100, 32'd7, 5'd6, 32'd14, 34);
        run32("remu", F3_REMU, 32'd100, 32'd7, 5'd7, 32'd2, 34);
        run32("divu0", F3_DIVU, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
        run32("rem0", F3_REM, 32'd5, 32'd0, 5'd9, 32'd5, 1);
        run32("divovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10,
              32'h8000_0000, 1);
        run32("removf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11,
              32'h0, 1);

        for (int i = 0; i < 8; i++) begin
            f3 = 3'(i);
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run32("rand", f3, ra, rb, 5'(i + 16), model32(f3, ra, rb), 34);
        end

        // backpressure holds the response
        bus32.out_ready = 1'b0;
        e.res = 32'd333; e.tag = 5'h1F; e.dbz = 1'b0; e.lat = 34;
        sb.push_back(e);
        bus32.funct3 = F3_DIVU; bus32.a = 32'd1000; bus32.b = 32'd3;
        bus32.tag_in = 5'h1F; bus32.in_valid = 1'b1;
        tick();
        lat = 1;
        bus32.in_valid = 1'b0;
        while (!bus32.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        check("bp.lat", lat, e.lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp.hold", {bus32.out_valid, bus32.in_ready,
                              bus32.tag_out, bus32.result},
                  {1'b1, 1'b0, e.tag, e.res});
        end
        bus32.out_ready = 1'b1;
        tick();
        check("bp.release.valid", bus32.out_valid, 0);
        check("bp.release.ready", bus32.in_ready, 1);

        // flush during CALC discards the op
        bus32.funct3 = F3_MUL; bus32.a = 32'd5; bus32.b = 32'd6;
        bus32.tag_in = 5'd2; bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus32.flush = 1'b1;
        tick();
        bus32.flush = 1'b0;
        check("flush.ready", bus32.in_ready, 1);
        check("flush.valid", bus32.out_valid, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus32.out_valid) seen++;
        end
        check("flush.no_valid", seen, 0);
        run32("postflush", F3_MUL, 32'd3, 32'd4, 5'd12, 32'd12, 34);

        // reset in the middle of a divide
        bus32.funct3 = F3_DIV; bus32.a = 32'd1000; bus32.b = 32'd7;
        bus32.tag_in = 5'd9; bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.ready", bus32.in_ready, 1);
        check("midrst.valid", bus32.out_valid, 0);
        check("midrst.result", bus32.result, 0);
        check("midrst.tag", bus32.tag_out, 0);
        check("midrst.dbz", bus32.div_by_zero, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus32.out_valid) seen++;
        end
        check("midrst.no_valid", seen, 0);
        run32("postrst", F3_DIVU, 32'd100, 32'd7, 5'd13, 32'd14, 34);

        // narrow instance
        run16("mulhu16", F3_MULHU, 16'hFFFF, 16'hFFFF, 5'd3, 16'hFFFE, 18);
        run16("div16", F3_DIV, 16'hFFF9, 16'd2, 5'd4, 16'hFFFD, 18);
        run16("divu16z", F3_DIVU, 16'd5, 16'd0, 5'd5, 16'hFFFF, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle RV32M multiply/divide unit; the parametrised next generation of the single-cycle ALU/ALUControl pair.
- Sits beside the ALU in the execute stage and handles funct7=0000001 R-type ops.
- Shift-add multiply and restoring divide, one bit per cycle.
- Valid/ready handshakes on input and output; a tag is carried through for the destination register.

Parameters:
XLEN, 32, operand/result width; any even value >= 8.
TAG_W, 5, width of the passthrough tag (rd index).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  request present.
in_ready  out  1  unit can accept; high only in IDLE.
funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
a  in  XLEN  rs1 operand.
b  in  XLEN  rs2 operand.
tag_in  in  TAG_W  opaque tag.
flush  in  1  synchronous abort of any in-flight op.
out_valid  out  1  result held valid.
out_ready  in  1  consumer accepts result.
result  out  XLEN  result word.
tag_out  out  TAG_W  tag of the op that produced result.
div_by_zero  out  1  flag, valid with out_valid.

Behaviour:
- Handshakes: accept when in_valid&&in_ready at a rising edge; operands, funct3 and tag are registered then. Input values are ignored outside accept edges.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - IDLE -> CALC: on accept, normal case.
  - IDLE -> DONE: on accept, special-case fast path.
  - CALC: exactly XLEN cycles, bit counter counts XLEN-1 down to 0; -> FIX when counter is 0.
  - FIX: 1 cycle of sign correction and hi/lo select; -> DONE.
  - DONE: out_valid=1; -> IDLE on out_ready.
- Latency, normal case: out_valid rises XLEN+2 edges after the accept edge (34 for XLEN=32).
- Latency, special cases: out_valid rises 1 edge after accept.
- No new accept in the cycle DONE retires, because in_ready is registered from state. Throughput is one op per XLEN+3 cycles minimum.
- Output hold: while out_valid && !out_ready, result, tag_out and div_by_zero stay stable.
- Multiply:
  - Operands are converted to magnitudes per signedness: MUL/MULH both signed, MULHSU a signed and b unsigned, MULHU both unsigned.
  - Forms a 2*XLEN unsigned product, negated in FIX when the signs differ.
  - MUL returns bits [XLEN-1:0]; the others return [2XLEN-1:XLEN].
- Divide:
  - Magnitudes for DIV/REM, raw values for DIVU/REMU; restoring divide.
  - In FIX, quotient is negated if sign(a)!=sign(b); remainder takes the sign of a. Division truncates toward zero.
- Special cases (fast path):
  - b==0: quotient = all ones, remainder = a, div_by_zero=1.
  - Signed DIV/REM with a=MIN, b=-1: quotient = MIN, remainder = 0, div_by_zero=0.
  - Multiply has no special cases.
- flush: in any state, next edge forces IDLE and out_valid=0, and the result is discarded. flush takes priority over a simultaneous accept or out_ready.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, tag_out=0, div_by_zero=0. Reset mid-operation abandons the op; no stale out_valid afterwards.
- rst takes priority over flush.

Decomposition:
- Shared package muldiv_pkg holds:
  - funct3 localparams (F3_MUL..F3_REMU);
  - state encoding (S_IDLE, S_CALC, S_FIX, S_DONE);
  - helper is_signed_a/is_signed_b function.
- One natural sub-module: muldiv_datapath, holding the shift registers, the XLEN+1 adder/subtractor, the counter and the FIX correction. muldiv_unit keeps the FSM, handshake and output registers.

Test Plan:
- MUL a=7, b=-3 -> result 0xFFFFFFEB after exactly 34 cycles; MULH a=-2, b=3 -> 0xFFFFFFFF; MULHU a=0xFFFFFFFF, b=2 -> 0x00000001.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU a=100, b=7 -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF, div_by_zero=1, out_valid 1 cycle after accept; REM a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000; REM of the same -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and tag_out (tag 0x1F) stable, in_ready=0. Release -> out_valid drops next edge and in_ready rises.
- flush at CALC cycle 10 with out_ready=1 -> IDLE next edge, no out_valid ever. A new MUL 3*4 issued afterwards -> 12.
- Assert rst for 1 cycle mid-divide -> all outputs at reset values on the next edge and in_ready=1. Repeat for XLEN=16: MULHU 0xFFFF*0xFFFF -> 0xFFFE with latency 18.
